// File: rtl/cellrv32_bus_switch.sv
`default_nettype none
// ============================================================================
// Module      : cellrv32_bus_switch
// Description : Two-master (A = data, fixed priority; B = fetch) to one-slave
//               bus switch with request latching and response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cellrv32_bus_switch #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // master A (CPU data port)
   input  logic        a_rden_i,
   input  logic        a_wren_i,
   input  logic [3:0]  a_ben_i,
   input  logic [31:0] a_addr_i,
   input  logic [31:0] a_data_i,
   output logic [31:0] a_data_o,
   output logic        a_ack_o,
   output logic        a_err_o,
   // master B (CPU instruction fetch)
   input  logic        b_rden_i,
   input  logic        b_wren_i,
   input  logic [3:0]  b_ben_i,
   input  logic [31:0] b_addr_i,
   input  logic [31:0] b_data_i,
   output logic [31:0] b_data_o,
   output logic        b_ack_o,
   output logic        b_err_o,
   // slave bus
   output logic        rden_o,
   output logic        wren_o,
   output logic [3:0]  ben_o,
   output logic [31:0] addr_o,
   output logic [31:0] data_o,
   output logic        src_o,
   input  logic [31:0] data_i,
   input  logic        ack_i,
   input  logic        err_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_BUSY_A = 2'b01,
      S_BUSY_B = 2'b10
   } state_t;

   localparam logic [7:0] c_CNT_LOAD = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;

   logic        r_pend_a_rd;
   logic        r_pend_a_wr;
   logic        r_pend_b_rd;
   logic        r_pend_b_wr;

   logic        w_a_rd_req;
   logic        w_a_wr_req;
   logic        w_b_rd_req;
   logic        w_b_wr_req;
   logic        w_iss_a_rd;
   logic        w_iss_a_wr;
   logic        w_iss_b_rd;
   logic        w_iss_b_wr;
   logic        w_src;
   logic        w_timeout;

   assign w_a_rd_req = a_rden_i | r_pend_a_rd;
   assign w_a_wr_req = a_wren_i | r_pend_a_wr;
   assign w_b_rd_req = b_rden_i | r_pend_b_rd;
   assign w_b_wr_req = b_wren_i | r_pend_b_wr;
   assign w_timeout  = (r_cnt == 8'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_iss_a_rd  = 1'b0;
      w_iss_a_wr  = 1'b0;
      w_iss_b_rd  = 1'b0;
      w_iss_b_wr  = 1'b0;
      w_src       = 1'b0;
      a_ack_o     = 1'b0;
      a_err_o     = 1'b0;
      a_data_o    = 32'd0;
      b_ack_o     = 1'b0;
      b_err_o     = 1'b0;
      b_data_o    = 32'd0;

      case (r_state)
         S_IDLE: begin
            // Reset also masks the combinational request path, so nothing
            // reaches the slave while rst_i is held.
            if (!rst_i) begin
               if (w_a_rd_req || w_a_wr_req) begin
                  w_iss_a_rd  = w_a_rd_req;
                  w_iss_a_wr  = ~w_a_rd_req;
                  w_state_nxt = S_BUSY_A;
                  w_cnt_nxt   = c_CNT_LOAD;
               end else if (w_b_rd_req || w_b_wr_req) begin
                  w_iss_b_rd  = w_b_rd_req;
                  w_iss_b_wr  = ~w_b_rd_req;
                  w_src       = 1'b1;
                  w_state_nxt = S_BUSY_B;
                  w_cnt_nxt   = c_CNT_LOAD;
               end
            end
         end

         S_BUSY_A: begin
            a_ack_o  = ack_i;
            a_data_o = ack_i ? data_i : 32'd0;
            a_err_o  = err_i | (~ack_i & w_timeout);
            if (ack_i || err_i || w_timeout) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         S_BUSY_B: begin
            w_src    = 1'b1;
            b_ack_o  = ack_i;
            b_data_o = ack_i ? data_i : 32'd0;
            b_err_o  = err_i | (~ack_i & w_timeout);
            if (ack_i || err_i || w_timeout) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign rden_o = w_iss_a_rd | w_iss_b_rd;
   assign wren_o = w_iss_a_wr | w_iss_b_wr;
   assign src_o  = w_src;
   assign addr_o = w_src ? b_addr_i : a_addr_i;
   assign data_o = w_src ? b_data_i : a_data_i;
   assign ben_o  = w_src ? b_ben_i  : a_ben_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_pend_a_rd <= 1'b0;
         r_pend_a_wr <= 1'b0;
         r_pend_b_rd <= 1'b0;
         r_pend_b_wr <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pend_a_rd <= (r_pend_a_rd | a_rden_i) & ~w_iss_a_rd;
         r_pend_a_wr <= (r_pend_a_wr | a_wren_i) & ~w_iss_a_wr;
         r_pend_b_rd <= (r_pend_b_rd | b_rden_i) & ~w_iss_b_rd;
         r_pend_b_wr <= (r_pend_b_wr | b_wren_i) & ~w_iss_b_wr;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_bus_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cellrv32_bus_switch
// Description : Directed scenarios plus random traffic against a transaction
//               model of the two-master bus switch (TIMEOUT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cellrv32_bus_switch;

   localparam int T = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        a_rden_i, a_wren_i, b_rden_i, b_wren_i;
   logic [3:0]  a_ben_i, b_ben_i, ben_o;
   logic [31:0] a_addr_i, a_data_i, b_addr_i, b_data_i;
   logic [31:0] a_data_o, b_data_o, addr_o, data_o, data_i;
   logic        a_ack_o, a_err_o, b_ack_o, b_err_o;
   logic        rden_o, wren_o, src_o, ack_i, err_i;

   int n_vec  = 0;
   int n_miss = 0;

   // transaction model: owner 0 = none, 1 = A, 2 = B; age = cycles since grant
   int   m_owner;
   int   m_age;
   logic m_pa_rd, m_pa_wr, m_pb_rd, m_pb_wr;

   cellrv32_bus_switch #(.TIMEOUT_CYCLES(T)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .a_rden_i(a_rden_i), .a_wren_i(a_wren_i), .a_ben_i(a_ben_i),
      .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_data_o(a_data_o),
      .a_ack_o(a_ack_o), .a_err_o(a_err_o),
      .b_rden_i(b_rden_i), .b_wren_i(b_wren_i), .b_ben_i(b_ben_i),
      .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_data_o(b_data_o),
      .b_ack_o(b_ack_o), .b_err_o(b_err_o),
      .rden_o(rden_o), .wren_o(wren_o), .ben_o(ben_o), .addr_o(addr_o),
      .data_o(data_o), .src_o(src_o), .data_i(data_i),
      .ack_i(ack_i), .err_i(err_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", tag, $time, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      rst_i    = 1'b0;
      a_rden_i = 1'b0; a_wren_i = 1'b0;
      b_rden_i = 1'b0; b_wren_i = 1'b0;
      ack_i    = 1'b0; err_i    = 1'b0;
      data_i   = 32'd0;
   endtask

   // Wait to the falling edge, compare every output with the model, then
   // advance the model to the state it holds after the next rising edge.
   task automatic eval();
      logic        e_rden, e_wren, e_src, e_aack, e_aerr, e_back, e_berr, e_rerr;
      logic [31:0] e_adata, e_bdata;
      logic        ea_rd, ea_wr, eb_rd, eb_wr;
      logic        ia_rd, ia_wr, ib_rd, ib_wr, done;
      int          gnt;
      #4;
      e_rden = 0; e_wren = 0; e_src = 0;
      e_aack = 0; e_aerr = 0; e_back = 0; e_berr = 0;
      e_adata = 0; e_bdata = 0;
      ia_rd = 0; ia_wr = 0; ib_rd = 0; ib_wr = 0; done = 0; gnt = 0;
      ea_rd = a_rden_i | m_pa_rd;
      ea_wr = a_wren_i | m_pa_wr;
      eb_rd = b_rden_i | m_pb_rd;
      eb_wr = b_wren_i | m_pb_wr;
      if (!rst_i) begin
         if (m_owner == 0) begin
            if (ea_rd)      begin e_rden = 1; ia_rd = 1; gnt = 1; end
            else if (ea_wr) begin e_wren = 1; ia_wr = 1; gnt = 1; end
            else if (eb_rd) begin e_rden = 1; ib_rd = 1; gnt = 2; e_src = 1; end
            else if (eb_wr) begin e_wren = 1; ib_wr = 1; gnt = 2; e_src = 1; end
         end else begin
            e_rerr = err_i | (!ack_i && m_age == T);
            done   = ack_i | err_i | (m_age == T);
            if (m_owner == 1) begin
               e_aack = ack_i; e_aerr = e_rerr; e_adata = ack_i ? data_i : 32'd0;
            end else begin
               e_src  = 1;
               e_back = ack_i; e_berr = e_rerr; e_bdata = ack_i ? data_i : 32'd0;
            end
         end
      end
      check("rden_o",   rden_o,   e_rden);
      check("wren_o",   wren_o,   e_wren);
      check("src_o",    src_o,    e_src);
      check("addr_o",   addr_o,   e_src ? b_addr_i : a_addr_i);
      check("data_o",   data_o,   e_src ? b_data_i : a_data_i);
      check("ben_o",    ben_o,    e_src ? b_ben_i  : a_ben_i);
      check("a_ack_o",  a_ack_o,  e_aack);
      check("a_err_o",  a_err_o,  e_aerr);
      check("a_data_o", a_data_o, e_adata);
      check("b_ack_o",  b_ack_o,  e_back);
      check("b_err_o",  b_err_o,  e_berr);
      check("b_data_o", b_data_o, e_bdata);
      if (rst_i) begin
         m_owner = 0; m_age = 0;
         m_pa_rd = 0; m_pa_wr = 0; m_pb_rd = 0; m_pb_wr = 0;
      end else begin
         m_pa_rd = ea_rd & ~ia_rd;
         m_pa_wr = ea_wr & ~ia_wr;
         m_pb_rd = eb_rd & ~ib_rd;
         m_pb_wr = eb_wr & ~ib_wr;
         if (gnt != 0)          begin m_owner = gnt; m_age = 1; end
         else if (done)         m_owner = 0;
         else if (m_owner != 0) m_age++;
      end
   endtask

   initial begin
      m_owner = 0; m_age = 0;
      m_pa_rd = 0; m_pa_wr = 0; m_pb_rd = 0; m_pb_wr = 0;
      clr();
      rst_i    = 1'b1;
      a_ben_i  = 4'hF; a_addr_i = 32'h0; a_data_i = 32'h0;
      b_ben_i  = 4'hF; b_addr_i = 32'h0; b_data_i = 32'h0;

      // reset state
      tick(); rst_i = 1'b1; a_addr_i = 32'h1234_5678; eval();
      check("rst_addr", addr_o, 32'h1234_5678);
      check("rst_rden", rden_o, 1'b0);
      tick(); clr(); eval();

      // A read in IDLE, acked next cycle
      tick(); clr(); a_rden_i = 1; a_addr_i = 32'h10; eval();
      check("ard_rden", rden_o, 1'b1);
      check("ard_src",  src_o,  1'b0);
      tick(); clr(); ack_i = 1; data_i = 32'hDEAD_BEEF; eval();
      check("ard_ack",  a_ack_o,  1'b1);
      check("ard_data", a_data_o, 32'hDEAD_BEEF);
      check("ard_back", b_ack_o,  1'b0);
      check("ard_bdat", b_data_o, 32'h0);

      // same-cycle A write and B read
      tick(); clr(); a_wren_i = 1; a_ben_i = 4'h3; a_data_i = 32'h0000_CAFE; a_addr_i = 32'h20;
      b_rden_i = 1; b_addr_i = 32'h100; eval();
      check("con_wren", wren_o, 1'b1);
      check("con_data", data_o, 32'h0000_CAFE);
      check("con_ben",  ben_o,  4'h3);
      tick(); clr(); ack_i = 1; eval();
      check("con_aack", a_ack_o, 1'b1);
      tick(); clr(); eval();
      check("con_rden", rden_o, 1'b1);
      check("con_src",  src_o,  1'b1);
      check("con_addr", addr_o, 32'h100);
      tick(); clr(); ack_i = 1; data_i = 32'h600D_F00D; eval();
      check("con_back", b_ack_o, 1'b1);

      // timeout on A read, then a late ack in IDLE
      tick(); clr(); a_rden_i = 1; a_addr_i = 32'h30; eval();
      for (int k = 1; k < T; k++) begin
         tick(); clr(); eval();
         check("to_early", a_err_o, 1'b0);
      end
      tick(); clr(); eval();
      check("to_err", a_err_o, 1'b1);
      tick(); clr(); ack_i = 1; data_i = 32'h5555_AAAA; eval();
      check("late_aack", a_ack_o, 1'b0);
      check("late_back", b_ack_o, 1'b0);

      // slave error on B access with A latched behind it
      tick(); clr(); b_rden_i = 1; b_addr_i = 32'h200; eval();
      tick(); clr(); a_rden_i = 1; a_addr_i = 32'h40; eval();
      tick(); clr(); err_i = 1; eval();
      check("berr_b", b_err_o, 1'b1);
      check("berr_a", a_err_o, 1'b0);
      tick(); clr(); eval();
      check("berr_next_rd",  rden_o, 1'b1);
      check("berr_next_src", src_o,  1'b0);
      tick(); clr(); ack_i = 1; eval();

      // async reset in BUSY_B with A pending
      tick(); clr(); b_rden_i = 1; eval();
      tick(); clr(); a_rden_i = 1; eval();
      tick(); clr(); rst_i = 1; eval();
      check("rstb_src",  src_o,   1'b0);
      check("rstb_berr", b_err_o, 1'b0);
      tick(); clr(); eval();
      check("rstb_norq", rden_o, 1'b0);
      tick(); clr(); ack_i = 1; data_i = 32'h1; eval();
      check("rstb_aack", a_ack_o, 1'b0);
      check("rstb_back", b_ack_o, 1'b0);

      // ack in the same cycle the timeout expires
      tick(); clr(); a_rden_i = 1; eval();
      for (int k = 1; k < T; k++) begin
         tick(); clr(); eval();
      end
      tick(); clr(); ack_i = 1; data_i = 32'h7777_0000; eval();
      check("edge_ack", a_ack_o, 1'b1);
      check("edge_err", a_err_o, 1'b0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick(); clr();
         rst_i    = ($urandom_range(299) == 0);
         a_rden_i = ($urandom_range(3) == 0);
         a_wren_i = ($urandom_range(5) == 0);
         b_rden_i = ($urandom_range(3) == 0);
         b_wren_i = ($urandom_range(7) == 0);
         a_ben_i  = 4'($urandom);  b_ben_i  = 4'($urandom);
         a_addr_i = $urandom;      b_addr_i = $urandom;
         a_data_i = $urandom;      b_data_i = $urandom;
         ack_i    = ($urandom_range(9) < 3);
         err_i    = ($urandom_range(11) == 0);
         data_i   = ack_i ? $urandom : 32'd0;
         eval();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cellrv32_bus_switch.md
# cellrv32_bus_switch

Two-master to one-slave bus arbiter that sits directly upstream of the processor-internal DMEM and the rest of the processor bus. It merges the CPU data port (master A, fixed priority) and the CPU instruction-fetch port (master B) onto one request/acknowledge bus. It latches single-cycle requests that arrive while the bus is busy, forwards ack/err/read data to the owning master only, and generates an error response if a slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles before a missing ack is answered with an error; legal range 2..255.

Ports:
- clk_i  in  1  global clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- a_rden_i / a_wren_i  in  1 / 1  master A read / write request pulses, single-cycle each
- a_ben_i  in  4  master A byte enables
- a_addr_i  in  32  master A address
- a_data_i  in  32  master A write data
- a_data_o  out  32  master A read data
- a_ack_o / a_err_o  out  1 / 1  master A acknowledge / error
- b_rden_i, b_wren_i, b_ben_i, b_addr_i, b_data_i, b_data_o, b_ack_o, b_err_o: same as the A ports, for master B
- rden_o / wren_o  out  1 / 1  slave read / write request pulses, single-cycle each
- ben_o  out  4  slave byte enables
- addr_o  out  32  slave address
- data_o  out  32  slave write data
- src_o  out  1  access source: 0 = A, 1 = B
- data_i  in  32  slave read data; 0 when not acking
- ack_i / err_i  in  1 / 1  slave acknowledge / error

## Operation
- Masters hold addr/ben/wdata stable from their request cycle until their own ack_o or err_o. The switch does not register these buses.
- Pending flags pend_a_rd, pend_a_wr, pend_b_rd, pend_b_wr:
  - Set by the corresponding request pulse when that request is not issued in the same cycle.
  - Cleared when that request is issued.
- Effective request of master X = incoming pulse OR its pending flag.
- FSM states: IDLE, BUSY_A, BUSY_B.
- IDLE:
  - If A has an effective request, select A. Otherwise, if B has one, select B.
  - For the selected master, assert rden_o/wren_o combinationally in this cycle. Drive the slave address/data/ben buses and src_o from that master.
  - Go to BUSY_A or BUSY_B. Load the timeout counter with TIMEOUT_CYCLES-1.
- BUSY_X:
  - Slave address/data/ben buses and src_o track master X. rden_o = wren_o = 0.
  - ack_i=1: x_ack_o = 1 and x_data_o = data_i, combinationally. Go to IDLE.
  - err_i=1: x_err_o = 1. Go to IDLE. If ack_i and err_i are both 1, both are forwarded.
  - Neither asserted and counter = 0: x_err_o = 1 (timeout). Go to IDLE.
  - Otherwise, decrement the counter.
- Output gating:
  - Non-owning master's ack/err/data outputs = 0 at all times.
  - a_data_o / b_data_o = 0 except in the ack cycle.
  - In IDLE with no request, slave buses are driven from master A and rden_o/wren_o = 0.
- Priority: strict A over B. Starvation of B is acceptable because a stalled fetch blocks new data accesses.
- A read and a write flagged for the same master at once (protocol violation): read is issued first, the write stays pending.
- A new request from the master currently being served is latched as pending and issued after the current access.

## Timing
- Reset values:
  - state = IDLE, all pending flags = 0, counter = 0.
  - All outputs = 0, apart from the slave address/data/ben buses, which mirror master A.
- Request to slave: 0 cycles. A request pulse in IDLE appears on rden_o/wren_o in the same cycle.
- Request under contention: B's pending request is issued in the cycle after A's ack/err. One IDLE cycle separates any two slave accesses.
- Ack to master: 0 added cycles. DMEM access: request at t, ack_i at t+1, master ack at t+1.
- Timeout: grant at cycle t means err_o at cycle t+TIMEOUT_CYCLES unless ack/err arrive first. An ack in that same cycle takes precedence over the timeout error.
- ack_i/err_i arriving in IDLE (late response after a timeout or reset) are ignored and not forwarded.
- Reset asserted mid-access: all state clears immediately. No ack/err is delivered to the interrupted master.

## Test plan
- A read 0x00000010 in IDLE:
  - rden_o=1, src_o=0 in cycle 0.
  - ack_i=1, data_i=0xDEADBEEF in cycle 1 -> a_ack_o=1, a_data_o=0xDEADBEEF, b_ack_o=0, b_data_o=0 in cycle 1.
- Same-cycle A write (ben=0x3, data 0x0000CAFE) and B read 0x00000100; slave acks after 1 cycle:
  - wren_o with A buses in cycle 0.
  - A ack in cycle 1.
  - rden_o, src_o=1, addr_o=0x100 in cycle 2.
  - b_ack_o in cycle 3.
- TIMEOUT_CYCLES=4, A read with no slave response -> a_err_o=1 exactly in cycle 4, state IDLE in cycle 5.
  - A spurious ack_i in cycle 5 produces no a_ack_o/b_ack_o.
- err_i=1 in cycle 2 of a B access -> b_err_o=1 in cycle 2, a_err_o=0. Next pending A request is issued in cycle 3.
- rst_i pulsed in BUSY_B with pend_a_rd set:
  - All outputs drop to 0 asynchronously.
  - After release, no request is issued and a following ack_i is ignored.
- TIMEOUT_CYCLES=4, ack_i arriving in the same cycle the counter reaches 0 -> ack forwarded, no err.
